// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  // Link defaults shared by the receiver, transmitter and divider
  localparam int UART_CLKS_PER_BIT = 1304;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with half-period option and terminal tick
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1304
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic load_half,
  output logic tick
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  // Tick on the last count of the selected period; the counter wraps to 0 at the same edge
  assign tick = !clear && (cnt == (load_half ? HALF_TC : FULL_TC));

  // Count up, restarting on clear or after each tick
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling and valid/ready output
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rxs;
  uart_state_e          state;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic                 tick;
  logic                 timer_clear;
  logic                 timer_half;

  // Two-flop synchronizer; reset to the idle (high) line level
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Timer held at zero while waiting for an edge so every frame starts from a clean count
  assign timer_clear = (state == ST_IDLE) || (state == ST_BREAK);
  assign timer_half  = (state == ST_START);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .clr      (clr),
    .clear    (timer_clear),
    .load_half(timer_half),
    .tick     (tick)
  );

  // Next shift value: new sample enters at the MSB so the first wire bit ends up at the LSB
  always_comb begin
    shreg_next                = shreg >> 1;
    shreg_next[DATA_BITS-1]   = rxs;
  end

  // Receive FSM, shift register, output register and handshake
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rxs)
            state <= ST_START;
        end

        ST_START: begin
          if (tick) begin
            if (rxs) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            shreg <= shreg_next;
            if (bit_idx == LAST_BIT)
              state <= ST_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (rxs) begin
              // Output may be refilled when empty or when it is being consumed this edge
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          if (rxs)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         valid_cycles = 0;
  int         rise_cnt = 0;
  int         last_rise = 0;
  logic [7:0] last_data = 8'h00;
  logic       valid_prev = 1'b0;
  int         ferr_cnt = 0;
  int         last_ferr = 0;
  int         ovr_cnt = 0;
  int         last_ovr = 0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log; stamps name the posedge that will sample the observed value
  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && !valid_prev) begin
      rise_cnt++;
      last_rise = cyc + 1;
      last_data = rx_data;
    end
    valid_prev = rx_valid;
    if (frame_err) begin
      ferr_cnt++;
      last_ferr = cyc + 1;
    end
    if (overrun) begin
      ovr_cnt++;
      last_ovr = cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // t0 is the edge where the receiver first sees the synchronized low level
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    @(posedge clk); #1;
    t0 = cyc + 3;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1; rx = d[k];
      repeat (CPB) @(posedge clk);
    end
    #1; rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
    if (stop) rx = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    clr = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic();
    int t0, r0, v0, f0, o0;
    rx_ready = 1'b1;
    r0 = rise_cnt; v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, t0);
    repeat (4) @(posedge clk); #1;
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", rise_cnt - r0); end
    checks++; if (last_rise !== t0 + 153) begin errors++; $display("FAIL basic_time: got %0d want %0d", last_rise, t0 + 153); end
    checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL basic_width: got %0d want 1", valid_cycles - v0); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", last_data); end
    checks++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin errors++; $display("FAIL basic_flags: got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
  endtask

  task automatic test_glitch();
    int r0, f0;
    r0 = rise_cnt; f0 = ferr_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (5) @(posedge clk); #1;
    rx = 1'b1;
    repeat (40) @(posedge clk); #1;
    checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", rise_cnt - r0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL glitch_state: got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_frame_err();
    int t0, r0, f0;
    rx_ready = 1'b1;
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0, t0);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    checks++; if (last_ferr !== t0 + 153) begin errors++; $display("FAIL ferr_time: got %0d want %0d", last_ferr, t0 + 153); end
    repeat (100) @(posedge clk); #1;
    checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", rise_cnt - r0); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_break: got %0d want 1", ferr_cnt - f0); end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h11, 1'b1, t0);
    repeat (4) @(posedge clk); #1;
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", rise_cnt - r0); end
    checks++; if (last_data !== 8'h11) begin errors++; $display("FAIL ferr_next_data: got %h want 11", last_data); end
  endtask

  task automatic test_overrun();
    int t0, t1, o0;
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, t0);
    send_frame(8'hC3, 1'b1, t1);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ovr_data: got %h want 3c", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0); end
    checks++; if (last_ovr !== t1 + 153) begin errors++; $display("FAIL ovr_time: got %0d want %0d", last_ovr, t1 + 153); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b want 0", rx_valid); end
  endtask

  task automatic test_clr();
    int t0, r0;
    logic [7:0] d;
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, t0);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL clr_pending: got %b want 1", rx_valid); end
    d = 8'hE6;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1; rx = d[k];
      repeat (CPB) @(posedge clk);
    end
    #1; rx = d[3];
    repeat (5) @(posedge clk); #1;
    clr = 1'b1;
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL clr_data: got %h want 00", rx_data); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL clr_flags: got %b want 00", {frame_err, overrun}); end
    repeat (2) @(posedge clk); #1;
    clr = 1'b0;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    rx_ready = 1'b1;
    r0 = rise_cnt;
    send_frame(8'h81, 1'b1, t0);
    repeat (4) @(posedge clk); #1;
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL clr_next_count: got %0d want 1", rise_cnt - r0); end
    checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL clr_next_data: got %h want 81", last_data); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, e2, o0;
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h00, 1'b1, t0);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL b2b_first_data: got %h want 00", rx_data); end
    e2 = cyc + 1;
    fork
      send_frame(8'hFF, 1'b1, t1);
      begin
        repeat (155) @(posedge clk);
        #1; rx_ready = 1'b1;
        @(posedge clk);
        #1; rx_ready = 1'b0;
      end
    join
    checks++; if (t1 !== e2 + 3) begin errors++; $display("FAIL b2b_align: got %0d want %0d", t1, e2 + 3); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_second_data: got %h want ff", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", rx_valid); end
    checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt - o0); end
    rx_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_clr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial 8N1 UART receiver: the input end of the link whose bit rate is set by the team's clock divider. It synchronizes the asynchronous `rx` line, detects and qualifies the start bit, samples each bit at its centre using an internal bit-period counter, and presents the received byte on a valid/ready output port. Framing errors and overruns are flagged as single-cycle pulses. It sits between the board's RX pin and the packet-parsing logic of the router.

## Interface
- `CLKS_PER_BIT`, 1304, `clk` cycles per serial bit (>= 4; matches a 652-cycle half period).
- `DATA_BITS`, 8, data bits per frame (1..8).
- `clk`  input  1  system clock.
- `clr`  input  1  reset, asynchronous, active-high; clock clk.
- `rx`  input  1  asynchronous serial line, idle high.
- `rx_data`  output  DATA_BITS  received byte, LSB = first bit on the wire; reset 0.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte; reset 0.
- `rx_ready`  input  1  consumer accepts the byte when `rx_valid && rx_ready` on a clk edge.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low; reset 0.
- `overrun`  output  1  one-cycle pulse: completed byte dropped because the output was still full; reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer, both flops reset to 1. All decisions use the synchronized value `rxs`.
- HALF = CLKS_PER_BIT/2, integer division. The bit counter is $clog2(CLKS_PER_BIT) bits wide and is cleared on every state entry and after every sample.
- IDLE: while `rxs`=0, go to START. Otherwise stay.
- START: sample `rxs` HALF cycles after entry. If it is 1, treat it as a glitch and return to IDLE with no flags. If it is 0, go to DATA with the bit index at 0.
- DATA: sample every CLKS_PER_BIT cycles. Shift the sample into the MSB of the shift register (right shift, LSB first on the wire). After DATA_BITS samples, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample = 1: deliver the byte (see below) and go to IDLE.
  - Sample = 0: pulse `frame_err`, discard the byte, and go to BREAK.
- BREAK: wait until `rxs`=1, then go to IDLE. A held-low line (break condition) never produces a byte.
- Delivery:
  - If the output is free (`rx_valid`=0), or is being consumed this cycle (`rx_valid && rx_ready`): load `rx_data` and set `rx_valid`=1. No overrun.
  - Otherwise: keep `rx_data` unchanged and pulse `overrun`. The new byte is lost.
- `rx_valid` clears on `rx_valid && rx_ready` unless a new byte is loaded in the same cycle. `rx_data` is stable while `rx_valid`=1.
- `clr` at any time forces IDLE, counters to 0 and all outputs to their reset values. Reception restarts cleanly on the next falling edge.

## Timing
- Pin-to-`rxs` latency: 2 cycles.
- Let T0 be the edge where IDLE sees `rxs`=0.
  - Start sample: T0+HALF.
  - Data bit k (k=0..DATA_BITS-1): T0+HALF+(k+1)·CLKS_PER_BIT.
  - Stop sample: T0+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
- `rx_valid`, `frame_err` and `overrun` are registered and change 1 cycle after the stop sample.
- Back-to-back frames: IDLE is reentered 1 cycle after the stop sample, so a start edge arriving half a bit later is detected.
- Tolerates ±4 % rate mismatch at 8 data bits.

## Structure
- Shared package `uart_pkg`:
  - State encoding IDLE/START/DATA/STOP/BREAK (3 bits).
  - Default CLKS_PER_BIT and DATA_BITS constants, also used by the transmitter and the divider.
- Sub-module `uart_bit_timer`: bit-period counter with `clear` and `load_half` inputs and a one-cycle `tick` output at terminal count. It is reusable by a future `uart_tx`.
- Top: synchronizer, FSM, shift register, output register, handshake.

## Test plan
All scenarios run with CLKS_PER_BIT=16, HALF=8.
- Send 0xA5 with `rx_ready`=1. Expect `rx_valid` high for exactly 1 cycle at T0+153, `rx_data`=0xA5, no flags.
- Drive `rx` low for 5 cycles, then high. Expect no `rx_valid`, no `frame_err`, and FSM back in IDLE.
- Send 0x5A with the stop bit = 0, then hold `rx` low for 100 cycles. Expect a `frame_err` pulse at T0+153, no `rx_valid`, and no new frame until `rx` returns high. A following 0x11 frame is received correctly.
- Send 0x3C then 0xC3 with `rx_ready`=0. Expect `rx_data` to stay 0x3C and an `overrun` pulse on the second frame. Raising `rx_ready` drops `rx_valid` the next cycle.
- Assert `clr` during data bit 3 of a frame. Expect all outputs at 0 immediately. The next frame, 0x81, is received as 0x81.
- Send 0x00 and 0xFF back-to-back with `rx_ready` pulsed on the same cycle the second byte completes. Expect both bytes delivered and no `overrun`.
